// File: rtl/ser_par_sync.sv
`default_nettype none
// ============================================================================
// Module   : ser_par_sync
// Purpose  : Single-clock serial-to-parallel converter with comma-based word
//            alignment and lock tracking. It searches for COMMA at any bit
//            phase, confirms alignment over LOCK_COUNT consecutive boundary
//            commas, and then delivers parallel words with valid/comma
//            qualifiers. Lock is dropped after UNLOCK_COUNT misaligned commas
//            or on a resync request.
// Ports    : clk_32f    - serial bit clock, one data_in bit per rising edge
//            reset      - asynchronous active-high reset
//            data_in    - serial data, MSB of each word first
//            resync     - synchronous request to restart the alignment search
//            active     - high while the aligner is locked (registered)
//            valid_out  - 1-cycle pulse, data_out holds a new non-comma word
//            comma_out  - 1-cycle pulse, aligned comma received while locked
//            data_out   - last word delivered, held between pulses
// Revision : 1.0 - initial release
// ============================================================================
module ser_par_sync #(
  parameter int unsigned       WIDTH        = 8,
  parameter logic [WIDTH-1:0]  COMMA        = WIDTH'(8'hBC),
  parameter int unsigned       LOCK_COUNT   = 4,
  parameter int unsigned       UNLOCK_COUNT = 3
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  input  logic             resync,
  output logic             active,
  output logic             valid_out,
  output logic             comma_out,
  output logic [WIDTH-1:0] data_out
);

  // --------------------------------------------------------------------------
  // Counter widths and their compare constants
  // --------------------------------------------------------------------------
  localparam int unsigned c_bit_w  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned c_lock_w = $clog2(LOCK_COUNT + 1);
  localparam int unsigned c_unlk_w = $clog2(UNLOCK_COUNT + 1);

  localparam logic [c_bit_w-1:0]  c_last_bit = c_bit_w'(WIDTH - 1);
  localparam logic [c_bit_w-1:0]  c_bit_one  = c_bit_w'(1);
  localparam logic [c_lock_w-1:0] c_lock_max = c_lock_w'(LOCK_COUNT);
  localparam logic [c_lock_w-1:0] c_lock_one = c_lock_w'(1);
  localparam logic [c_unlk_w-1:0] c_unlk_max = c_unlk_w'(UNLOCK_COUNT);
  localparam logic [c_unlk_w-1:0] c_unlk_one = c_unlk_w'(1);

  // --------------------------------------------------------------------------
  // Alignment state machine encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registers and next-state values
  // --------------------------------------------------------------------------
  state_t              state_q,      state_d;
  logic [WIDTH-1:0]    sr_q,         sr_d;
  logic [c_bit_w-1:0]  bit_cnt_q,    bit_cnt_d;
  logic [c_lock_w-1:0] comma_cnt_q,  comma_cnt_d;
  logic [c_unlk_w-1:0] misalign_q,   misalign_d;
  logic                active_q,     active_d;
  logic                valid_q,      valid_d;
  logic                comma_q,      comma_d;
  logic [WIDTH-1:0]    data_q,       data_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                w_is_comma;
  logic                w_boundary;
  logic [c_bit_w-1:0]  w_bit_next;
  logic [c_lock_w-1:0] w_comma_inc;
  logic [c_unlk_w-1:0] w_mis_inc;

  // The shift register always advances; the window including this edge's bit
  // is what every comma/word decision on this edge looks at.
  assign sr_d       = {sr_q[WIDTH-2:0], data_in};
  assign w_is_comma = (sr_d == COMMA);

  // A word completes on the last bit position, but only once a phase has
  // been chosen (bit_cnt carries no meaning while hunting).
  assign w_boundary = (bit_cnt_q == c_last_bit) && (state_q != ST_HUNT);

  // Bit position wraps explicitly so non-power-of-two widths work.
  assign w_bit_next = (bit_cnt_q == c_last_bit) ? '0 : (bit_cnt_q + c_bit_one);

  // Saturating increments; saturation doubles as the "reached" condition.
  assign w_comma_inc = (comma_cnt_q == c_lock_max) ? comma_cnt_q
                                                   : (comma_cnt_q + c_lock_one);
  assign w_mis_inc   = (misalign_q == c_unlk_max) ? misalign_q
                                                  : (misalign_q + c_unlk_one);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HUNT;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      misalign_q  <= '0;
      active_q    <= 1'b0;
      valid_q     <= 1'b0;
      comma_q     <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      misalign_q  <= misalign_d;
      active_q    <= active_d;
      valid_q     <= valid_d;
      comma_q     <= comma_d;
      data_q      <= data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = w_bit_next;
    comma_cnt_d = comma_cnt_q;
    misalign_d  = misalign_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    comma_d     = 1'b0;

    if (resync) begin
      // Resync overrides everything, including a word completing this edge;
      // data_out deliberately keeps the last delivered word.
      state_d     = ST_HUNT;
      bit_cnt_d   = '0;
      comma_cnt_d = '0;
      misalign_d  = '0;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (w_is_comma) begin
            // The comma just completed, so the next bit starts a word.
            bit_cnt_d   = '0;
            comma_cnt_d = c_lock_one;
            misalign_d  = '0;
            state_d     = (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
          end
        end

        ST_VERIFY: begin
          if (w_boundary) begin
            if (w_is_comma) begin
              comma_cnt_d = w_comma_inc;
              if (w_comma_inc == c_lock_max) begin
                state_d    = ST_LOCKED;
                misalign_d = '0;
              end
            end else begin
              state_d     = ST_HUNT;
              comma_cnt_d = '0;
            end
          end
        end

        ST_LOCKED: begin
          if (w_boundary) begin
            data_d = sr_d;
            if (w_is_comma) begin
              comma_d    = 1'b1;
              misalign_d = '0;
            end else begin
              valid_d = 1'b1;
            end
          end else if (w_is_comma) begin
            // A comma off the word boundary suggests the bit phase slipped.
            if (w_mis_inc == c_unlk_max) begin
              // Re-anchor on this comma; it counts as the first verified one.
              state_d     = ST_VERIFY;
              bit_cnt_d   = '0;
              comma_cnt_d = c_lock_one;
              misalign_d  = '0;
            end else begin
              misalign_d = w_mis_inc;
            end
          end
        end

        default: begin
          state_d     = ST_HUNT;
          comma_cnt_d = '0;
          misalign_d  = '0;
        end
      endcase
    end

    active_d = (state_d == ST_LOCKED);
  end

  // --------------------------------------------------------------------------
  // Outputs come straight from registers
  // --------------------------------------------------------------------------
  assign active    = active_q;
  assign valid_out = valid_q;
  assign comma_out = comma_q;
  assign data_out  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_ser_par_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_ser_par_sync
// Purpose  : Self-checking bench for ser_par_sync (WIDTH=8, COMMA=8'hBC,
//            LOCK_COUNT=4, UNLOCK_COUNT=3). Word-level vector table plus
//            hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ser_par_sync;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic       data_in = 1'b0;
  logic       resync  = 1'b0;
  logic       active;
  logic       valid_out;
  logic       comma_out;
  logic [7:0] data_out;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int mid_v  = 0;
  int mid_c  = 0;
  int t0     = 0;

  ser_par_sync #(
    .WIDTH        (8),
    .COMMA        (8'hBC),
    .LOCK_COUNT   (4),
    .UNLOCK_COUNT (3)
  ) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .resync    (resync),
    .active    (active),
    .valid_out (valid_out),
    .comma_out (comma_out),
    .data_out  (data_out)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct packed {
    logic       rst;
    logic [7:0] word;
    logic       act;
    logic       vld;
    logic       cma;
    logic [7:0] dat;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Drives one bit away from the edge, then samples outputs 1 unit after it.
  task automatic send_bit(input logic b, input logic rs);
    data_in = b;
    resync  = rs;
    @(posedge clk_32f);
    #1;
    cyc++;
  endtask

  // Sends a word MSB first; pulses seen on the first 7 bits are counted,
  // outputs after the last bit are left for the caller to check.
  task automatic send_word(input logic [7:0] w, input logic rs_last);
    mid_v = 0;
    mid_c = 0;
    for (int i = 7; i >= 1; i--) begin
      send_bit(w[i], 1'b0);
      if (valid_out) mid_v++;
      if (comma_out) mid_c++;
    end
    send_bit(w[0], rs_last);
    resync = 1'b0;
  endtask

  // Asserts reset between edges and checks that outputs clear at once.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_active", 32'(active),    32'd0);
    check("rst_valid",  32'(valid_out), 32'd0);
    check("rst_comma",  32'(comma_out), 32'd0);
    check("rst_data",   32'(data_out),  32'd0);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // rst, word, active, valid, comma, data (after the word's last bit)
    tbl[0]  = '{1'b1, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 8'hBC, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 8'h5A, 1'b1, 1'b1, 1'b0, 8'h5A};
    tbl[5]  = '{1'b0, 8'hBC, 1'b1, 1'b0, 1'b1, 8'hBC};
    tbl[6]  = '{1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 8'h11};
    tbl[7]  = '{1'b0, 8'hBC, 1'b1, 1'b0, 1'b1, 8'hBC};
    tbl[8]  = '{1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 8'h22};
    tbl[9]  = '{1'b1, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[12] = '{1'b0, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[13] = '{1'b0, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[14] = '{1'b0, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[15] = '{1'b0, 8'hBC, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[16] = '{1'b0, 8'h5A, 1'b1, 1'b1, 1'b0, 8'h5A};

    #1;
    do_reset();

    // Basic lock, locked traffic, and a VERIFY failure with relock
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].rst) do_reset();
      send_word(tbl[i].word, 1'b0);
      check($sformatf("v%0d_active", i), 32'(active),    32'(tbl[i].act));
      check($sformatf("v%0d_valid", i),  32'(valid_out), 32'(tbl[i].vld));
      check($sformatf("v%0d_comma", i),  32'(comma_out), 32'(tbl[i].cma));
      check($sformatf("v%0d_data", i),   32'(data_out),  32'(tbl[i].dat));
      check($sformatf("v%0d_midpulse", i), 32'(mid_v + mid_c), 32'd0);
    end

    // Alignment found at bit offset 3
    do_reset();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    t0 = cyc + 1;
    for (int i = 0; i < 4; i++) send_word(8'hBC, 1'b0);
    check("off3_active", 32'(active), 32'd1);
    send_word(8'h3C, 1'b0);
    check("off3_valid", 32'(valid_out), 32'd1);
    check("off3_data",  32'(data_out),  32'h3C);
    check("off3_latency", 32'(cyc - t0), 32'd39);

    // One-bit slip while locked: boundary words read as 8'h5E, the comma
    // lands one bit late; the third misaligned comma drops lock.
    do_reset();
    for (int i = 0; i < 4; i++) send_word(8'hBC, 1'b0);
    check("slip_prelock", 32'(active), 32'd1);
    send_bit(1'b0, 1'b0);
    send_word(8'hBC, 1'b0);
    check("slip1_active",   32'(active),  32'd1);
    check("slip1_midvalid", 32'(mid_v),   32'd1);
    check("slip1_data",     32'(data_out), 32'h5E);
    check("slip1_valid",    32'(valid_out), 32'd0);
    send_word(8'hBC, 1'b0);
    check("slip2_active",   32'(active),  32'd1);
    send_word(8'hBC, 1'b0);
    check("slip3_active",   32'(active),  32'd0);
    send_word(8'hBC, 1'b0);
    check("slip4_active",   32'(active),  32'd0);
    send_word(8'hBC, 1'b0);
    check("slip5_active",   32'(active),  32'd0);
    send_word(8'hBC, 1'b0);
    check("slip6_active",   32'(active),  32'd1);
    check("slip6_pulse",    32'(valid_out | comma_out), 32'd0);
    send_word(8'hA5, 1'b0);
    check("slip7_valid",    32'(valid_out), 32'd1);
    check("slip7_data",     32'(data_out),  32'hA5);
    check("slip7_midpulse", 32'(mid_v + mid_c), 32'd0);

    // Reset in the middle of a word while locked
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    check("midrst_pre_active", 32'(active), 32'd1);
    do_reset();

    // Resync on a boundary edge carrying 8'h77
    for (int i = 0; i < 4; i++) send_word(8'hBC, 1'b0);
    send_word(8'h11, 1'b0);
    check("rs_pre_valid", 32'(valid_out), 32'd1);
    check("rs_pre_data",  32'(data_out),  32'h11);
    send_word(8'h77, 1'b1);
    check("rs_valid",  32'(valid_out), 32'd0);
    check("rs_comma",  32'(comma_out), 32'd0);
    check("rs_active", 32'(active),    32'd0);
    check("rs_data",   32'(data_out),  32'h11);
    send_bit(1'b0, 1'b0);
    check("rs_next_active", 32'(active),   32'd0);
    check("rs_next_data",   32'(data_out), 32'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
